reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised successor to the core's single-write register file.
- Provides NREAD combinational read ports, two write ports (ALU/writeback and load/late-result) and write-through bypass.
- Adds a per-register pending-write scoreboard so issue logic can detect RAW hazards without a separate structure.
- Sits in the core's decode/issue stage; the writeback stage drives the write ports.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  core clock, all state updates on rising edge
resetn  in  1  asynchronous active-low reset
raddr  in  NREAD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rdata  out  NREAD*DATA_W  packed read data
rpend  out  NREAD  pending-write flag per read port
wen0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
wen1  in  1  write enable, port 1 (higher priority)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
rsv_en  in  1  reserve: mark rsv_addr as having an outstanding producer
rsv_addr  in  ADDR_W  register to reserve
flush  in  1  clear all pending bits (pipeline flush); data untouched
pend_cnt  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset (resetn=0, asynchronous): all registers = 0, all pending bits = 0, pend_cnt = 0. rdata reflects zeroed array; rpend = 0. Reset deasserted mid-operation: resumes from cleared state, no partial updates.
- Writes, on posedge clk:
  - wenX=1 stores wdataX at waddrX.
  - Both ports writing the same address: port 1 data stored.
  - Different addresses: both stored.
- Reads, 0 latency, combinational:
  - rdata[i] = array[raddr[i]].
  - With BYPASS=1: if wen1 && waddr1==raddr[i], return wdata1; else if wen0 && waddr0==raddr[i], return wdata0.
  - With BYPASS=0: pre-edge array value.
- Zero register (ZERO_REG=1): reads of index 0 return 0 (bypass included); writes and reserves to 0 ignored; pending bit 0 never set.
- Scoreboard, per-register pend[r], updated on posedge, in priority order:
  1. flush=1: all pend cleared; an rsv_en in the same cycle is also dropped.
  2. Otherwise rsv_en sets pend[rsv_addr].
  3. A write on either port clears pend[waddr], unless the same cycle reserves that address; reserve wins (new producer).
  4. Re-reserving an already-pending register leaves it pending; no count change.
- rpend[i] = pend[raddr[i]], combinational. With BYPASS=1, a same-cycle write to raddr[i] with no same-cycle reserve to it forces rpend[i]=0, since the data is already forwarded.
- pend_cnt:
  - Registered population count of pend.
  - Equals the popcount of the next pend vector, so it is valid the cycle after any change.
  - Range 0..2**ADDR_W (minus 1 when ZERO_REG); cannot wrap.
- No handshake stalls: all operations accepted every cycle.

Decomposition:
- Package rf_pkg: default DATA_W/ADDR_W localparams, NREAD_MAX=4, helper function for packed-port slicing.
- Sub-module rf_scoreboard: pend vector, priority update, popcount register.
- Top level holds the data array, write arbitration and bypass muxes.

Test Plan:
1. Reset, then write r5=0x12345678 via port 0; next cycle read r5 on port 0 -> rdata=0x12345678; read r0 on port 1 -> 0.
2. Same cycle wen0 r7=0xAAAA0000 and wen1 r7=0x5555FFFF, with raddr0=7 -> bypass rdata=0x5555FFFF that cycle; array holds 0x5555FFFF after the edge.
3. rsv_en r3 -> next cycle rpend=1 on raddr=3, pend_cnt=1. Then wen0 r3=0x1 -> same cycle rpend=0 with rdata=0x1 (BYPASS); next cycle pend_cnt=0.
4. Same cycle rsv_en r9 and wen1 r9 -> r9 pending afterwards, data updated, pend_cnt increments by 1.
5. Reserve r1,r2,r4 over three cycles (pend_cnt=3), then flush together with rsv_en r6 -> pend_cnt=0, all rpend=0.
6. Write r10=0xDEADBEEF, assert resetn=0 between clock edges -> rdata on raddr=10 becomes 0 immediately; rsv_en r0 afterwards -> pend_cnt stays 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package rf_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned NREAD_MAX = 4;

   // LSB position of field idx in a packed bus of w-bit fields
   function automatic int unsigned port_lsb(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with a registered population count.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   rsv_en_i,
   input  logic [ADDR_W-1:0]      rsv_addr_i,
   input  logic                   wen0_i,
   input  logic [ADDR_W-1:0]      waddr0_i,
   input  logic                   wen1_i,
   input  logic [ADDR_W-1:0]      waddr1_i,
   output logic [(2**ADDR_W)-1:0] pend_o,
   output logic [ADDR_W:0]        pend_cnt_o
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] pend_d, pend_q;
   logic [ADDR_W:0]  cnt_d, cnt_q;
   logic             rsv_ok;

   assign rsv_ok = rsv_en_i && !((ZERO_REG != 0) && (rsv_addr_i == ADDR_W'(0)));

   // Flush beats everything; a reserve beats a completing write to the same register
   always_comb begin
      pend_d = pend_q;
      if (flush_i) begin
         pend_d = '0;
      end else begin
         if (wen0_i) pend_d[waddr0_i] = 1'b0;
         if (wen1_i) pend_d[waddr1_i] = 1'b0;
         if (rsv_ok) pend_d[rsv_addr_i] = 1'b1;
      end
      if (ZERO_REG != 0) pend_d[0] = 1'b0;
      cnt_d = '0;
      for (int r = 0; r < DEPTH; r++) begin
         cnt_d = cnt_d + (ADDR_W+1)'(pend_d[r]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_o     = pend_q;
   assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read, dual-write register file with write-through bypass and RAW scoreboard.
module reg_file_sb
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NREAD*ADDR_W-1:0]   raddr,
   output logic [NREAD*DATA_W-1:0]   rdata,
   output logic [NREAD-1:0]          rpend,
   input  logic                      wen0,
   input  logic [ADDR_W-1:0]         waddr0,
   input  logic [DATA_W-1:0]         wdata0,
   input  logic                      wen1,
   input  logic [ADDR_W-1:0]         waddr1,
   input  logic [DATA_W-1:0]         wdata1,
   input  logic                      rsv_en,
   input  logic [ADDR_W-1:0]         rsv_addr,
   input  logic                      flush,
   output logic [ADDR_W:0]           pend_cnt
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic              we0_ok, we1_ok;

   assign we0_ok = wen0 && !((ZERO_REG != 0) && (waddr0 == ADDR_W'(0)));
   assign we1_ok = wen1 && !((ZERO_REG != 0) && (waddr1 == ADDR_W'(0)));

   // Port 1 is written last so it wins an address collision
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      end else begin
         if (we0_ok) mem_q[waddr0] <= wdata0;
         if (we1_ok) mem_q[waddr1] <= wdata1;
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .rst_n      (resetn),
      .flush_i    (flush),
      .rsv_en_i   (rsv_en),
      .rsv_addr_i (rsv_addr),
      .wen0_i     (wen0),
      .waddr0_i   (waddr0),
      .wen1_i     (wen1),
      .waddr1_i   (waddr1),
      .pend_o     (pend),
      .pend_cnt_o (pend_cnt)
   );

   // Read muxes: forwarded write data counts as already produced, unless re-reserved
   always_comb begin
      rdata = '0;
      rpend = '0;
      for (int i = 0; i < NREAD; i++) begin
         logic [ADDR_W-1:0] ra;
         logic [DATA_W-1:0] d;
         logic              p;
         logic              hit0, hit1;
         ra   = raddr[port_lsb(i, ADDR_W) +: ADDR_W];
         hit0 = wen0 && (waddr0 == ra);
         hit1 = wen1 && (waddr1 == ra);
         d    = mem_q[ra];
         p    = pend[ra];
         if (BYPASS != 0) begin
            if (hit1)      d = wdata1;
            else if (hit0) d = wdata0;
            if ((hit0 || hit1) && !(rsv_en && (rsv_addr == ra))) p = 1'b0;
         end
         if ((ZERO_REG != 0) && (ra == ADDR_W'(0))) begin
            d = '0;
            p = 1'b0;
         end
         rdata[port_lsb(i, DATA_W) +: DATA_W] = d;
         rpend[i]                            = p;
      end
   end

endmodule
